// File: rtl/mmio_timer_pkg.sv
// Register map, CTRL field layout and bus lane helpers shared by the mmio_timer block.
package mmio_timer_pkg;

  localparam logic [1:0] OFS_CTRL    = 2'd0;
  localparam logic [1:0] OFS_COUNT   = 2'd1;
  localparam logic [1:0] OFS_COMPARE = 2'd2;
  localparam logic [1:0] OFS_STATUS  = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_IRQM    = 2;
  localparam int CTRL_PRE_LSB = 8;
  localparam int CTRL_PRE_MSB = 15;

  localparam int STATUS_MATCH = 0;

  typedef struct packed {
    logic [7:0] prescale;
    logic       irqm;
    logic       auto_rl;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN]                   = c.en;
    w[CTRL_AUTO]                 = c.auto_rl;
    w[CTRL_IRQM]                 = c.irqm;
    w[CTRL_PRE_MSB:CTRL_PRE_LSB] = c.prescale;
    return w;
  endfunction

  // Byte writes replace only the addressed lane; the new byte always arrives in wd[7:0].
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic byte_acc, input logic [1:0] lane);
    logic [31:0] mask;
    if (!byte_acc) return wd;
    mask = 32'h0000_00FF << {lane, 3'b000};
    return (old & ~mask) | ((wd & 32'h0000_00FF) << {lane, 3'b000});
  endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// Processor data-memory bus as seen by a memory-mapped responder.
interface mmio_timer_if;
  logic        MemWrite;
  logic        ByteMem;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;

  modport master (output MemWrite, ByteMem, DataAdr, WriteData, input ReadData, hit);
  modport slave  (input MemWrite, ByteMem, DataAdr, WriteData, output ReadData, hit);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Divides the timer clock: counts 0..limit while enabled, ticking on the terminal value.
module mmio_timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] limit,
  output logic       tick
);
  logic [7:0] cnt_q;

  assign tick = en & (cnt_q == limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt_q <= '0;
    else if (clr || !en)   cnt_q <= '0;
    else if (tick)         cnt_q <= '0;
    else                   cnt_q <= cnt_q + 8'd1;
  end
endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare/match; irq is live only when TIMER_IRQ_EN is defined.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          CNT_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  mmio_timer_if.slave  bus,
  output logic         irq
);
  logic [1:0]           ofs, lane;
  logic                 hit_c, wr;
  logic                 wr_ctrl, wr_count, wr_cmp, wr_status, w1c;
  logic [31:0]          reg_word, rd_word, wr_word;
  ctrl_t                ctrl_q;
  logic [CNT_WIDTH-1:0] count_q, cmp_q;
  logic                 match_q;
  logic                 tick, cnt_eq, hw_match;

  assign ofs   = bus.DataAdr[3:2];
  assign lane  = bus.DataAdr[1:0];
  assign hit_c = (bus.DataAdr[31:4] == BASE_ADDR[31:4]);
  assign wr    = bus.MemWrite & hit_c;

  assign wr_ctrl   = wr && (ofs == OFS_CTRL);
  assign wr_count  = wr && (ofs == OFS_COUNT);
  assign wr_cmp    = wr && (ofs == OFS_COMPARE);
  assign wr_status = wr && (ofs == OFS_STATUS);
  // Only a set bit 0 landing on lane 0 clears MATCH; writes to upper status lanes are no-ops.
  assign w1c = bus.WriteData[STATUS_MATCH] && (!bus.ByteMem || lane == 2'd0);

  always_comb begin
    reg_word = '0;
    case (ofs)
      OFS_CTRL:    reg_word = ctrl_word(ctrl_q);
      OFS_COUNT:   reg_word = 32'(count_q);
      OFS_COMPARE: reg_word = 32'(cmp_q);
      default:     reg_word[STATUS_MATCH] = match_q;
    endcase
  end

  assign rd_word      = bus.ByteMem ? ((reg_word >> {lane, 3'b000}) & 32'h0000_00FF) : reg_word;
  assign bus.ReadData = hit_c ? rd_word : 32'h0;
  assign bus.hit      = hit_c;
  assign wr_word      = lane_merge(reg_word, bus.WriteData, bus.ByteMem, lane);

  mmio_timer_prescaler u_pre (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q.en),
    .clr   (wr_ctrl),
    .limit (ctrl_q.prescale),
    .tick  (tick)
  );

  assign cnt_eq   = (count_q == cmp_q);
  assign hw_match = tick & cnt_eq;

  // Software writes to CTRL/COUNT override the hardware update of the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= '1;
      match_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q.en       <= wr_word[CTRL_EN];
        ctrl_q.auto_rl  <= wr_word[CTRL_AUTO];
        ctrl_q.irqm     <= wr_word[CTRL_IRQM];
        ctrl_q.prescale <= wr_word[CTRL_PRE_MSB:CTRL_PRE_LSB];
      end else if (hw_match && !ctrl_q.auto_rl) begin
        ctrl_q.en <= 1'b0;
      end

      if (wr_count)
        count_q <= CNT_WIDTH'(wr_word);
      else if (tick)
        count_q <= cnt_eq ? (ctrl_q.auto_rl ? '0 : count_q) : count_q + CNT_WIDTH'(1);

      if (wr_cmp) cmp_q <= CNT_WIDTH'(wr_word);

      if (hw_match)                match_q <= 1'b1;
      else if (wr_status && w1c)   match_q <= 1'b0;
    end
  end

`ifdef TIMER_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= match_q & ctrl_q.irqm;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_timer.sv
// Directed plus randomized bus traffic against a cycle-level behavioural model of the timer.
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef TIMER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq;
  int   errs = 0, checks = 0;

  mmio_timer_if bus();

  mmio_timer #(.BASE_ADDR(BASE), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  bit        m_en, m_auto, m_irqm, m_match, m_irq;
  bit [7:0]  m_ps, m_pre;
  bit [31:0] m_cnt, m_cmp;

  task automatic m_reset();
    m_en = 0; m_auto = 0; m_irqm = 0; m_match = 0; m_irq = 0;
    m_ps = 0; m_pre = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
  endtask

  function automatic bit in_win(input logic [31:0] adr);
    return adr[31:4] == BASE[31:4];
  endfunction

  function automatic bit [31:0] m_reg(input logic [1:0] ofs);
    case (ofs)
      2'd0:    return {16'h0, m_ps, 5'h0, m_irqm, m_auto, m_en};
      2'd1:    return m_cnt;
      2'd2:    return m_cmp;
      default: return {31'h0, m_match};
    endcase
  endfunction

  function automatic bit [31:0] m_read(input logic [31:0] adr, input logic bm);
    bit [31:0] w;
    if (!in_win(adr)) return 32'h0;
    w = m_reg(adr[3:2]);
    if (bm) return (w >> (8 * adr[1:0])) & 32'hFF;
    return w;
  endfunction

  // One clock edge of timer behaviour: hardware event first, then the bus write overrides.
  task automatic m_step(input logic we, input logic bm, input logic [31:0] adr, input logic [31:0] wd);
    bit tick, hwm;
    bit n_en, n_match;
    bit [7:0] n_pre;
    bit [31:0] n_cnt, nw;
    tick    = m_en && (m_pre == m_ps);
    hwm     = tick && (m_cnt == m_cmp);
    n_pre   = !m_en ? 8'd0 : (tick ? 8'd0 : m_pre + 8'd1);
    n_cnt   = m_cnt;
    n_en    = m_en;
    n_match = m_match;
    if (tick) begin
      if (hwm) begin
        if (m_auto) n_cnt = 0;
        else        n_en = 0;
      end else n_cnt = m_cnt + 1;
    end
    if (IRQ_ON) m_irq = m_match && m_irqm;
    if (we && in_win(adr)) begin
      nw = m_reg(adr[3:2]);
      if (bm) nw[8*adr[1:0] +: 8] = wd[7:0];
      else    nw = wd;
      case (adr[3:2])
        2'd0: begin n_en = nw[0]; m_auto = nw[1]; m_irqm = nw[2]; m_ps = nw[15:8]; n_pre = 0; end
        2'd1: n_cnt = nw;
        2'd2: m_cmp = nw;
        default: if (wd[0] && (!bm || adr[1:0] == 2'd0)) n_match = 0;
      endcase
    end
    if (hwm) n_match = 1;
    m_en = n_en; m_pre = n_pre; m_cnt = n_cnt; m_match = n_match;
  endtask

  // One bus cycle: drive just after the edge, check mid-cycle, advance model at the edge.
  task automatic cyc(input logic we, input logic bm, input logic [31:0] adr, input logic [31:0] wd);
    bus.MemWrite = we; bus.ByteMem = bm; bus.DataAdr = adr; bus.WriteData = wd;
    #2;
    chk("rd",  bus.ReadData, m_read(adr, bm));
    chk("hit", bus.hit, in_win(adr));
    chk("irq", irq, m_irq);
    @(posedge clk);
    m_step(we, bm, adr, wd);
    #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic wr32(input logic [31:0] adr, input logic [31:0] d); cyc(1'b1, 1'b0, adr, d); endtask
  task automatic idle(input int n); repeat (n) cyc(1'b0, 1'b0, BASE + 32'h4, 32'h0); endtask

  task automatic peek(input string tag, input logic [31:0] adr, input logic bm, input logic [31:0] exp);
    bus.MemWrite = 1'b0; bus.ByteMem = bm; bus.DataAdr = adr;
    #1;
    chk(tag, bus.ReadData, exp);
    chk({tag, "_model"}, bus.ReadData, m_read(adr, bm));
  endtask

  initial begin
    bus.MemWrite = 0; bus.ByteMem = 0; bus.DataAdr = 0; bus.WriteData = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    peek("rst_ctrl", BASE, 1'b0, 32'h0);
    peek("rst_cmp",  BASE + 32'h8, 1'b0, 32'hFFFF_FFFF);
    peek("rst_stat", BASE + 32'hC, 1'b0, 32'h0);
    chk("rst_irq", irq, 1'b0);
    reset = 1'b1;

    // auto-reload, PRESCALE=0
    wr32(BASE + 32'h8, 32'd3);
    wr32(BASE, 32'h3);
    peek("ar_cnt0", BASE + 32'h4, 1'b0, 32'd0);
    for (int v = 1; v <= 3; v++) begin
      idle(1);
      peek("ar_cnt", BASE + 32'h4, 1'b0, 32'(v));
    end
    peek("ar_nomatch", BASE + 32'hC, 1'b0, 32'h0);
    idle(1);
    peek("ar_wrap", BASE + 32'h4, 1'b0, 32'd0);
    peek("ar_match", BASE + 32'hC, 1'b0, 32'h1);
    wr32(BASE + 32'hC, 32'h1);
    peek("ar_w1c", BASE + 32'hC, 1'b0, 32'h0);
    wr32(BASE, 32'h0);

    // PRESCALE=4, one-shot
    wr32(BASE + 32'h4, 32'd0);
    wr32(BASE + 32'h8, 32'd2);
    wr32(BASE, 32'h401);
    for (int v = 1; v <= 2; v++) begin
      idle(4);
      peek("ps_hold", BASE + 32'h4, 1'b0, 32'(v - 1));
      idle(1);
      peek("ps_step", BASE + 32'h4, 1'b0, 32'(v));
    end
    idle(4);
    peek("ps_pre", BASE + 32'hC, 1'b0, 32'h0);
    idle(1);
    peek("ps_en_off", BASE, 1'b0, 32'h400);
    peek("ps_match", BASE + 32'hC, 1'b0, 32'h1);
    idle(6);
    peek("ps_stay", BASE + 32'h4, 1'b0, 32'd2);
    wr32(BASE + 32'hC, 32'h1);

    // byte lanes and out-of-window write
    wr32(BASE + 32'h8, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b1, BASE + 32'h9, 32'h0000_00AB);
    peek("bl_word", BASE + 32'h8, 1'b0, 32'hFFFF_ABFF);
    peek("bl_byte", BASE + 32'h9, 1'b1, 32'h0000_00AB);
    wr32(32'h0000_0500, 32'h1234_5678);
    peek("oow_rd", 32'h0000_0500, 1'b0, 32'h0);
    chk("oow_hit", bus.hit, 1'b0);
    peek("oow_cmp", BASE + 32'h8, 1'b0, 32'hFFFF_ABFF);

    // collisions
    wr32(BASE + 32'h8, 32'd2);
    wr32(BASE + 32'h4, 32'd0);
    wr32(BASE, 32'h3);
    idle(2);
    peek("col_cnt", BASE + 32'h4, 1'b0, 32'd2);
    wr32(BASE + 32'hC, 32'h1);
    peek("col_match", BASE + 32'hC, 1'b0, 32'h1);
    wr32(BASE + 32'h4, 32'd7);
    peek("col_cnt7", BASE + 32'h4, 1'b0, 32'd7);
    wr32(BASE, 32'h0);
    wr32(BASE + 32'hC, 32'h1);

    // wrap from all-ones without a match
    wr32(BASE + 32'h8, 32'd5);
    wr32(BASE + 32'h4, 32'hFFFF_FFFE);
    wr32(BASE, 32'h1);
    idle(1);
    peek("wr_ff", BASE + 32'h4, 1'b0, 32'hFFFF_FFFF);
    idle(1);
    peek("wr_zero", BASE + 32'h4, 1'b0, 32'h0);
    peek("wr_noflag", BASE + 32'hC, 1'b0, 32'h0);
    wr32(BASE, 32'h0);

    // interrupt path
    wr32(BASE + 32'h8, 32'd1);
    wr32(BASE + 32'h4, 32'd0);
    wr32(BASE, 32'h7);
    idle(2);
    peek("irq_stat", BASE + 32'hC, 1'b0, 32'h1);
    chk("irq_lag", irq, 1'b0);
    idle(1);
    chk("irq_rise", irq, IRQ_ON);
    wr32(BASE, 32'h3);
    idle(1);
    chk("irq_mask", irq, 1'b0);

    // asynchronous reset mid-count
    wr32(BASE, 32'h0);
    wr32(BASE + 32'h8, 32'd100);
    wr32(BASE + 32'h4, 32'd0);
    wr32(BASE, 32'h5);
    idle(5);
    peek("mr_cnt5", BASE + 32'h4, 1'b0, 32'd5);
    chk("mr_irq_pre", irq, IRQ_ON);
    reset = 1'b0;
    #1;
    m_reset();
    peek("mr_cnt", BASE + 32'h4, 1'b0, 32'd0);
    chk("mr_irq", irq, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    peek("mr_ctrl", BASE, 1'b0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int kind;
      logic bm;
      logic [1:0] ofs, lane;
      logic [31:0] adr, wd;
      kind = $urandom_range(0, 9);
      bm   = 1'($urandom_range(0, 1));
      ofs  = 2'($urandom_range(0, 3));
      lane = bm ? 2'($urandom_range(0, 3)) : 2'd0;
      adr  = BASE + {28'h0, ofs, lane};
      wd   = $urandom;
      if (ofs == 2'd0) begin
        wd[15:8] = 8'($urandom_range(0, 3));
        if (bm && lane == 2'd1) wd[7:0] = 8'($urandom_range(0, 3));
      end
      if (ofs == 2'd1 || ofs == 2'd2) wd = bm ? {24'h0, 8'($urandom_range(0, 12))} : 32'($urandom_range(0, 12));
      if (kind == 9) adr = $urandom_range(0, 1) ? 32'h0000_0500 + 32'($urandom_range(0, 15)) : 32'h0000_03FC;
      cyc(kind >= 4, bm, adr, wd);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer peripheral that answers the processor's data-memory bus (MemWrite, ByteMem, DataAdr, WriteData, ReadData) as a responder inside a fixed address window.
- Sits beside dmem in top; top muxes ReadData from dmem or mmio_timer using the `hit` output.
- Provides a prescaled up-counter, a compare register, a sticky match flag and an optional interrupt line.

Parameters:
- BASE_ADDR, 32'h0000_0400, word-aligned base of the 16-byte register window.
- CNT_WIDTH, 32, width of COUNT and COMPARE (8..32); upper read bits zero.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- MemWrite  input  1  write strobe from processor, sampled on clk rise.
- ByteMem  input  1  1 = byte access (lane DataAdr[1:0]), 0 = word access.
- DataAdr  input  32  byte address from processor.
- WriteData  input  32  write data; for byte writes the byte is in WriteData[7:0].
- ReadData  output  32  combinational read data for a hit address, else 0.
- hit  output  1  combinational; 1 when DataAdr[31:4] == BASE_ADDR[31:4].
- irq  output  1  registered interrupt request; held 0 unless TIMER_IRQ_EN is defined.

Behaviour:
- Register map (offset = DataAdr[3:2]):
  - 0x0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_MASK, bits15:8 PRESCALE; other bits read 0.
  - 0x4 COUNT
  - 0x8 COMPARE
  - 0xC STATUS: bit0 MATCH, write-1-to-clear.
- Reset (reset=0, asynchronous): CTRL=0, COUNT=0, COMPARE={CNT_WIDTH{1'b1}}, STATUS=0, prescaler=0, irq=0.
- Reads: zero-latency combinational.
  - Word read returns the register.
  - Byte read returns the lane selected by DataAdr[1:0], zero-extended.
  - No read side effects.
- Writes: take effect on the clk edge where MemWrite=1 and hit=1.
  - Byte write updates only the addressed lane.
  - Writes outside the window are ignored.
- Prescaler:
  - When EN=1 it counts 0..PRESCALE and emits tick when prescaler==PRESCALE, then wraps to 0.
  - PRESCALE=0 gives a tick every cycle.
  - Any write to CTRL clears the prescaler.
  - EN=0 holds the prescaler at 0.
- On tick with COUNT==COMPARE:
  - MATCH<=1.
  - If AUTO_RELOAD=1: COUNT<=0 and EN stays 1.
  - If AUTO_RELOAD=0: EN<=0 and COUNT holds (one-shot).
- On tick with COUNT!=COMPARE: COUNT<=COUNT+1, modulo 2^CNT_WIDTH (wrap from all-ones to 0, no flag).
- Simultaneous events:
  - A software write to COUNT or CTRL wins over the hardware update in the same cycle.
  - A hardware MATCH set wins over a W1C clear in the same cycle.
- Timing: the match is visible in STATUS one cycle after the tick cycle.
- Reset mid-count: all state returns to reset values immediately; no pending tick survives.

Optional Feature:
- TIMER_IRQ_EN defined:
  - irq is a register; irq <= MATCH & IRQ_MASK each cycle, so it lags STATUS by one cycle.
  - irq deasserts the cycle after MATCH is cleared or IRQ_MASK is written 0.
- TIMER_IRQ_EN undefined:
  - irq is tied to 0.
  - IRQ_MASK bit is still writable and readable but has no effect.

Decomposition:
- Package mmio_timer_pkg holds:
  - register offsets: OFS_CTRL, OFS_COUNT, OFS_COMPARE, OFS_STATUS;
  - CTRL bit positions: CTRL_EN, CTRL_AUTO, CTRL_IRQM, CTRL_PRE_LSB, CTRL_PRE_MSB;
  - STATUS_MATCH;
  - a packed struct typedef for CTRL.
- One sub-module, mmio_timer_prescaler: 8-bit counter with inputs en, clr, limit and output tick.
- Bus decode, registers and match logic stay in mmio_timer.

Test Plan:
- Reset: hold reset=0 three cycles → ReadData(0x400)=0, ReadData(0x408)=32'hFFFF_FFFF, STATUS=0, irq=0.
- Auto-reload: COMPARE=3, CTRL=0x0000_0003 (PRESCALE=0) → COUNT goes 0,1,2,3,0; MATCH=1 one cycle after the tick at COUNT=3; a W1C write of 1 to 0x40C clears it.
- Prescale: COMPARE=2, CTRL=0x0000_0401 (PRESCALE=4, one-shot) → COUNT increments every 5 cycles; after reaching 2 and matching, EN reads 0 and COUNT stays 2.
- Byte lanes: byte write 0xAB to 0x409 → COMPARE=32'hFFFF_ABFF; byte read of 0x409 → ReadData=32'h0000_00AB; word write to 0x500 → no register changes and hit=0.
- Collision: in the same cycle as a MATCH-setting tick, write 1 to STATUS → MATCH reads 1; write COUNT=7 during a tick → COUNT=7.
- TIMER_IRQ_EN defined: CTRL=0x0000_0007, COMPARE=1 → irq rises one cycle after MATCH; writing CTRL with IRQ_MASK=0 → irq low next cycle. Reset mid-count at COUNT=5 → COUNT=0 and irq=0 immediately.
